mvm_frame_ctrl: RTL
===================

# mvm_frame_ctrl

Frame controller between the UART byte links and the matrix-vector multiply core in the UART MVM system. It assembles received bytes into one K/X operand bus and hands it to the MVM core over a valid/ready handshake. It captures the MVM result, then sign-extends or truncates each row and streams the rows back to the UART transmitter byte by byte. Receive and transmit sides run concurrently, so frame N+1 can arrive while frame N is still being sent; an inter-byte timeout resynchronises framing.

## Interface
- R, 2, matrix rows
- C, 2, matrix columns
- W_X, 4, signed x element width
- W_K, 2, signed k element width
- W_Y_OUT, 8, transmitted width per output row
- BITS_PER_WORD, 8, UART word width
- TIMEOUT_CYCLES, 256, idle cycles that abort a partial frame
- Derived (not overridable):
  - W_Y = W_X+W_K+$clog2(C)
  - W_BUS_KX = R*C*W_K + C*W_X
  - N_WORDS_KX = W_BUS_KX/BITS_PER_WORD
  - N_WORDS_Y = R*W_Y_OUT/BITS_PER_WORD
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- rx_valid  in  1  one-cycle strobe, byte received
- rx_data  in  BITS_PER_WORD  received byte
- kx_valid  out  1  operand bus valid to MVM
- kx_ready  in  1  MVM accepts operands
- kx_data  out  W_BUS_KX  {k, x}; x in the low C*W_X bits, k[r][c] packed row-major above
- y_valid  in  1  MVM result valid
- y_ready  out  1  controller can accept a result
- y_data  in  R*W_Y  row r at bits [r*W_Y +: W_Y]
- tx_valid  out  1  byte available to UART TX
- tx_ready  in  1  UART TX accepts byte
- tx_data  out  BITS_PER_WORD  byte to transmit
- err_timeout  out  1  one-cycle pulse, partial frame discarded
- err_overrun  out  1  one-cycle pulse, byte dropped
- frame_cnt  out  8  completed TX frames, wraps 255→0

## Operation
- RX FSM states:
  - RX_FILL: on rx_valid, store the byte at word index wcnt and increment wcnt. Word 0 is the LSB of kx_data. When byte N_WORDS_KX-1 is stored, go to RX_HOLD.
  - RX_HOLD: kx_valid=1 and kx_data is stable. On kx_valid&&kx_ready, clear wcnt and go to RX_FILL. An rx_valid arriving in RX_HOLD, including the handshake cycle, drops the byte and pulses err_overrun.
- Timeout (RX_FILL only, wcnt>0):
  - The idle counter resets on every accepted byte.
  - When it reaches TIMEOUT_CYCLES-1, clear wcnt and pulse err_timeout.
  - If rx_valid arrives in the same cycle, the byte wins: it is accepted and no timeout occurs.
- TX FSM states:
  - TX_IDLE: y_ready=1. On y_valid&&y_ready, capture all R rows into the output buffer and go to TX_SEND.
  - TX_SEND: tx_valid=1 and tx_data = buffer word tcnt. tcnt advances on tx_valid&&tx_ready. After word N_WORDS_Y-1 handshakes, increment frame_cnt and go to TX_IDLE.
- Width rule: each row is converted to W_Y_OUT bits (two's-complement wrap).
  - If W_Y_OUT ≥ W_Y, sign-extend.
  - Otherwise keep the low W_Y_OUT bits.
  - Row 0 occupies the lowest bytes.
- The RX and TX FSMs are independent; the controller never stalls rx.

## Timing
- Reset values:
  - kx_valid=0, tx_valid=0, err_*=0, frame_cnt=0
  - y_ready=1 (TX_IDLE)
  - kx_data and tx_data =0
  - wcnt, tcnt and the idle counter =0
- rstn low mid-frame discards all buffered and partial data immediately (asynchronously).
- Latencies:
  - kx_valid rises the cycle after the last byte's rx_valid.
  - tx_valid rises the cycle after the y handshake.
  - y_ready rises the cycle after the last tx handshake.
- No combinational path from kx_ready, y_valid or tx_ready to any output.
- kx_data and tx_data are held stable while valid is high and ready is low.

## Structure
- Package mvm_uart_pkg holds the derived width localparams and the enums rx_state_e {RX_FILL, RX_HOLD} and tx_state_e {TX_IDLE, TX_SEND}.
- The sub-module mvm_frame_serializer holds the TX side: y capture, width conversion and byte streaming.
- The RX assembly and timeout logic stay in the top.

## Test plan
Default parameters give 2 RX bytes and 2 TX bytes per frame.
- Basic frame:
  - Stimulus: rx 0x21 then 0x1B, kx_ready=1.
  - Required: kx_data=0x1B21. The bench MVM model returns y_data with row0=7'h7B and row1=7'h01.
  - Required: tx bytes 0xFB then 0x01, frame_cnt=1.
- Backpressure:
  - Stimulus: hold kx_ready=0 for 50 cycles; hold tx_ready=0 for 30 cycles mid-frame.
  - Required: kx_data and tx_data stable throughout; no bytes lost.
  - Stimulus: a byte sent during RX_HOLD.
  - Required: err_overrun pulses once and wcnt is unchanged.
- Timeout:
  - Stimulus: 1 byte, then 256 idle cycles.
  - Required: err_timeout pulses exactly once; the next 2 bytes form a correct frame.
  - Stimulus: the byte arrives exactly at cycle 255.
  - Required: the byte is accepted and no timeout pulse occurs.
- Overlap:
  - Stimulus: frame 2 arrives while frame 1 is in TX_SEND with a slow tx_ready.
  - Required: both results are transmitted in order and frame_cnt=2.
- Reset mid-TX:
  - Stimulus: assert rstn low after the first TX byte.
  - Required: tx_valid=0 immediately and frame_cnt=0; after release, the next frame processes normally.
- Soak:
  - Stimulus: 10 random frames with random gaps of 1–100 cycles against the scoreboard MVM model.
  - Required: every frame matches the model.

Source files
------------

// File: rtl/mvm_uart_pkg.sv
// Shared widths, state enums and payload types for the UART MVM frame controller.
package mvm_uart_pkg;

  localparam int unsigned R              = 2;
  localparam int unsigned C              = 2;
  localparam int unsigned W_X            = 4;
  localparam int unsigned W_K            = 2;
  localparam int unsigned W_Y_OUT        = 8;
  localparam int unsigned BITS_PER_WORD  = 8;
  localparam int unsigned TIMEOUT_CYCLES = 256;

  localparam int unsigned W_Y        = W_X + W_K + $clog2(C);
  localparam int unsigned W_BUS_KX   = R * C * W_K + C * W_X;
  localparam int unsigned N_WORDS_KX = W_BUS_KX / BITS_PER_WORD;
  localparam int unsigned N_WORDS_Y  = R * W_Y_OUT / BITS_PER_WORD;

  localparam int unsigned WCNT_W = $clog2(N_WORDS_KX + 1);
  localparam int unsigned TCNT_W = $clog2(N_WORDS_Y + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned FCNT_W = 8;

  typedef enum logic {RX_FILL, RX_HOLD} rx_state_e;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  // k sits above x; k[r][c] at flat index (r*C+c)*W_K within the k field
  typedef struct packed {
    logic [R*C*W_K-1:0] k;
    logic [C*W_X-1:0]   x;
  } kx_bus_t;

  typedef logic [R-1:0][W_Y-1:0] y_bus_t;

  // Two's-complement resize of one result row: sign-extends when widening, wraps when narrowing
  function automatic logic [W_Y_OUT-1:0] fit_row(input logic [W_Y-1:0] row);
    return W_Y_OUT'(signed'(row));
  endfunction

endpackage

// File: rtl/mvm_frame_ctrl_if.sv
// Byte links, operand/result handshakes and status of the frame controller.
interface mvm_frame_ctrl_if;
  import mvm_uart_pkg::*;

  logic                      rx_valid;
  logic [BITS_PER_WORD-1:0]  rx_data;
  logic                      kx_valid;
  logic                      kx_ready;
  kx_bus_t                   kx_data;
  logic                      y_valid;
  logic                      y_ready;
  y_bus_t                    y_data;
  logic                      tx_valid;
  logic                      tx_ready;
  logic [BITS_PER_WORD-1:0]  tx_data;
  logic                      err_timeout;
  logic                      err_overrun;
  logic [FCNT_W-1:0]         frame_cnt;

  modport master (
    input  rx_valid, rx_data, kx_ready, y_valid, y_data, tx_ready,
    output kx_valid, kx_data, y_ready, tx_valid, tx_data,
           err_timeout, err_overrun, frame_cnt
  );

  modport slave (
    output rx_valid, rx_data, kx_ready, y_valid, y_data, tx_ready,
    input  kx_valid, kx_data, y_ready, tx_valid, tx_data,
           err_timeout, err_overrun, frame_cnt
  );
endinterface

// File: rtl/mvm_frame_serializer.sv
// TX side: captures an MVM result, resizes each row and streams it out LSB byte first.
module mvm_frame_serializer
  import mvm_uart_pkg::*;
(
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     y_valid,
  output logic                     y_ready,
  input  y_bus_t                   y_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [BITS_PER_WORD-1:0] tx_data,
  output logic [FCNT_W-1:0]        frame_cnt
);

  localparam int unsigned W_BUF = N_WORDS_Y * BITS_PER_WORD;

  tx_state_e            state_q, state_n;
  logic [TCNT_W-1:0]    tcnt_q;
  logic [W_BUF-1:0]     sbuf_q;
  logic [W_BUF-1:0]     packed_c;
  logic                 capture_c, advance_c, last_c;

  always_comb begin
    packed_c = '0;
    for (int r = 0; r < R; r++) packed_c[r*W_Y_OUT +: W_Y_OUT] = fit_row(y_data[r]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= TX_IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    capture_c = 1'b0;
    advance_c = 1'b0;
    last_c    = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (y_valid && y_ready) begin
          capture_c = 1'b1;
          state_n   = TX_SEND;
        end
      end
      TX_SEND: begin
        if (tx_valid && tx_ready) begin
          advance_c = 1'b1;
          if (tcnt_q == TCNT_W'(N_WORDS_Y - 1)) begin
            last_c  = 1'b1;
            state_n = TX_IDLE;
          end
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

  // Shift buffer keeps the current byte in its low bits so tx_data is a plain register slice
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y_ready   <= 1'b1;
      tx_valid  <= 1'b0;
      tcnt_q    <= '0;
      sbuf_q    <= '0;
      frame_cnt <= '0;
    end else begin
      y_ready  <= (state_n == TX_IDLE);
      tx_valid <= (state_n == TX_SEND);
      if (capture_c) begin
        sbuf_q <= packed_c;
        tcnt_q <= '0;
      end else if (advance_c) begin
        sbuf_q <= sbuf_q >> BITS_PER_WORD;
        tcnt_q <= last_c ? '0 : tcnt_q + TCNT_W'(1);
      end
      if (last_c) frame_cnt <= frame_cnt + FCNT_W'(1);
    end
  end

  assign tx_data = sbuf_q[BITS_PER_WORD-1:0];

endmodule

// File: rtl/mvm_frame_ctrl.sv
// Frame controller: assembles UART bytes into the K/X operand bus and hands
// MVM results to the serializer; RX and TX run independently.
module mvm_frame_ctrl
  import mvm_uart_pkg::*;
(
  input logic              clk,
  input logic              rstn,
  mvm_frame_ctrl_if.master bus
);

  rx_state_e             rx_state_q, rx_state_n;
  logic [WCNT_W-1:0]     wcnt_q;
  logic [IDLE_W-1:0]     idle_q;
  logic [W_BUS_KX-1:0]   kx_q;
  logic                  kx_valid_q, err_timeout_q, err_overrun_q;
  logic                  accept_c, last_c, overrun_c, timeout_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rx_state_q <= RX_FILL;
    else       rx_state_q <= rx_state_n;
  end

  // A byte arriving on the timeout cycle is accepted instead of aborting the frame
  always_comb begin
    rx_state_n = rx_state_q;
    accept_c   = 1'b0;
    last_c     = 1'b0;
    overrun_c  = 1'b0;
    timeout_c  = 1'b0;
    case (rx_state_q)
      RX_FILL: begin
        if (bus.rx_valid) begin
          accept_c = 1'b1;
          if (wcnt_q == WCNT_W'(N_WORDS_KX - 1)) begin
            last_c     = 1'b1;
            rx_state_n = RX_HOLD;
          end
        end else if (wcnt_q != '0 && idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_c = 1'b1;
        end
      end
      RX_HOLD: begin
        overrun_c = bus.rx_valid;
        if (kx_valid_q && bus.kx_ready) rx_state_n = RX_FILL;
      end
      default: rx_state_n = RX_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      kx_q          <= '0;
      wcnt_q        <= '0;
      idle_q        <= '0;
      kx_valid_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      kx_valid_q    <= (rx_state_n == RX_HOLD);
      err_timeout_q <= timeout_c;
      err_overrun_q <= overrun_c;
      if (accept_c) begin
        for (int i = 0; i < N_WORDS_KX; i++)
          if (wcnt_q == WCNT_W'(i)) kx_q[i*BITS_PER_WORD +: BITS_PER_WORD] <= bus.rx_data;
        wcnt_q <= last_c ? '0 : wcnt_q + WCNT_W'(1);
        idle_q <= '0;
      end else if (timeout_c) begin
        wcnt_q <= '0;
        idle_q <= '0;
      end else if (rx_state_q == RX_FILL && wcnt_q != '0) begin
        idle_q <= idle_q + IDLE_W'(1);
      end else begin
        idle_q <= '0;
      end
    end
  end

  assign bus.kx_valid    = kx_valid_q;
  assign bus.kx_data     = kx_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_overrun = err_overrun_q;

  mvm_frame_serializer u_serializer (
    .clk       (clk),
    .rstn      (rstn),
    .y_valid   (bus.y_valid),
    .y_ready   (bus.y_ready),
    .y_data    (bus.y_data),
    .tx_valid  (bus.tx_valid),
    .tx_ready  (bus.tx_ready),
    .tx_data   (bus.tx_data),
    .frame_cnt (bus.frame_cnt)
  );

endmodule
